// File: rtl/div_reconstruct_mul_if.sv
// Start/done bundle for the reconstructing multiply-accumulate unit.
// The master drives operands and start; the slave returns status and result.
interface div_reconstruct_mul_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] R;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             overflow;

   modport master (
      output start, Q, B, R,
      input  busy, done, result, overflow
   );

   modport slave (
      input  start, Q, B, R,
      output busy, done, result, overflow
   );
endinterface

// File: rtl/div_reconstruct_mul.sv
// Sequential shift-add unit computing Q*B+R, the inverse of the divider.
// Fixed WIDTH-cycle latency; result/overflow held until the next accepted start.
module div_reconstruct_mul #(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   div_reconstruct_mul_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state, state_n;
   logic [2*WIDTH-1:0] acc, acc_n;
   logic [2*WIDTH-1:0] mcand, mcand_n;
   logic [WIDTH-1:0]   mplier, mplier_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [WIDTH-1:0]   res_q, res_n;
   logic               ovf_q, ovf_n;
   logic [2*WIDTH-1:0] acc_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         res_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         state  <= state_n;
         acc    <= acc_n;
         mcand  <= mcand_n;
         mplier <= mplier_n;
         cnt    <= cnt_n;
         res_q  <= res_n;
         ovf_q  <= ovf_n;
      end
   end

   // Upper half is zero-extended, so the 2W-bit sum can never carry out.
   assign acc_step = mplier[0] ? (acc + mcand) : acc;

   always_comb begin
      state_n  = state;
      acc_n    = acc;
      mcand_n  = mcand;
      mplier_n = mplier;
      cnt_n    = cnt;
      res_n    = res_q;
      ovf_n    = ovf_q;
      unique case (state)
         S_IDLE, S_DONE: begin
            state_n = S_IDLE;
            if (bus.start) begin
               acc_n    = {{WIDTH{1'b0}}, bus.R};
               mcand_n  = {{WIDTH{1'b0}}, bus.B};
               mplier_n = bus.Q;
               cnt_n    = '0;
               state_n  = S_RUN;
            end
         end
         S_RUN: begin
            acc_n    = acc_step;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt + CW'(1);
            if (cnt == LAST) begin
               state_n = S_DONE;
               res_n   = acc_step[WIDTH-1:0];
               ovf_n   = |acc_step[2*WIDTH-1:WIDTH];
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.busy     = (state == S_RUN);
   assign bus.done     = (state == S_DONE);
   assign bus.result   = res_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_div_reconstruct_mul.sv
// Directed bench for div_reconstruct_mul: vector table plus handshake,
// reset and hold sequences.
module tb_div_reconstruct_mul;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic [W-1:0] res;
      logic         ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   div_reconstruct_mul_if #(.WIDTH(W)) bus ();

   div_reconstruct_mul #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [W-1:0] q, input logic [W-1:0] b,
                        input logic [W-1:0] r);
      bus.start = 1'b1;
      bus.Q = q;
      bus.B = b;
      bus.R = r;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Called just after the accepting edge; lat = edges until done is seen.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat = -1;
      busy_cnt = 0;
      if (bus.busy) busy_cnt++;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = n;
            break;
         end
         if (bus.busy) busy_cnt++;
      end
   endtask

   vec_t vecs[9];
   int   lat, bcnt, errs, pulses;
   logic [W-1:0] a, d;

   initial begin
      vecs[0] = '{32'd7, 32'd5, 32'd3, 32'd38, 1'b0};
      vecs[1] = '{32'd14, 32'd7, 32'd2, 32'd100, 1'b0};
      vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1};
      vecs[3] = '{32'h0, 32'hDEADBEEF, 32'h1234, 32'h1234, 1'b0};
      vecs[4] = '{32'd6, 32'd7, 32'd0, 32'd42, 1'b0};
      vecs[5] = '{32'h10000, 32'h10000, 32'h0, 32'h0, 1'b1};
      vecs[6] = '{32'hFFFF, 32'h10001, 32'h0, 32'hFFFFFFFF, 1'b0};
      vecs[7] = '{32'hFFFF, 32'h10001, 32'h1, 32'h0, 1'b1};
      vecs[8] = '{32'h1, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0};

      bus.start = 1'b0;
      bus.Q = '0;
      bus.B = '0;
      bus.R = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_result", 64'(bus.result), 64'd0);
      chk("reset_ovf", 64'(bus.overflow), 64'd0);

      foreach (vecs[i]) begin
         issue(vecs[i].q, vecs[i].b, vecs[i].r);
         wait_done(lat, bcnt);
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd32);
         chk($sformatf("vec%0d_busy", i), 64'(bcnt), 64'd32);
         chk($sformatf("vec%0d_result", i), 64'(bus.result), 64'(vecs[i].res));
         chk($sformatf("vec%0d_ovf", i), 64'(bus.overflow), 64'(vecs[i].ovf));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
      end

      // Round trip through a reference division
      for (int k = 0; k < 20; k++) begin
         a = $urandom;
         d = $urandom_range(1, 32'hFFFF) << $urandom_range(0, 16);
         if (d == 0) d = 1;
         issue(a / d, d, a % d);
         wait_done(lat, bcnt);
         chk($sformatf("rt%0d_result", k), 64'(bus.result), 64'(a));
         chk($sformatf("rt%0d_ovf", k), 64'(bus.overflow), 64'd0);
      end

      // start during RUN is ignored; start in DONE is accepted
      issue(32'd3, 32'd4, 32'd0);
      bus.Q = 32'd9;
      bus.B = 32'd9;
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         bus.start = (n == 5 || n == 20);
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (bus.done) begin
            lat = n;
            break;
         end
      end
      chk("hs_lat", 64'(lat), 64'd32);
      chk("hs_result", 64'(bus.result), 64'd12);
      issue(32'd2, 32'd2, 32'd1);
      wait_done(lat, bcnt);
      chk("b2b_lat", 64'(lat), 64'd32);
      chk("b2b_result", 64'(bus.result), 64'd5);

      // Reset mid-operation
      issue(32'd100, 32'd100, 32'd0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_result", 64'(bus.result), 64'd0);
      pulses = 0;
      for (int n = 0; n < 40; n++) begin
         if (bus.done || bus.busy) pulses++;
         @(posedge clk);
         #1;
      end
      chk("mid_rst_quiet", 64'(pulses), 64'd0);
      issue(32'd6, 32'd7, 32'd0);
      wait_done(lat, bcnt);
      chk("post_rst_result", 64'(bus.result), 64'd42);

      // Hold through idle cycles
      issue(32'd7, 32'd5, 32'd3);
      wait_done(lat, bcnt);
      chk("hold_first", 64'(bus.result), 64'd38);
      errs = 0;
      for (int n = 0; n < 50; n++) begin
         @(posedge clk);
         #1;
         bus.Q = $urandom;
         bus.B = $urandom;
         bus.R = $urandom;
         if (bus.result !== 32'd38 || bus.overflow !== 1'b0 ||
             bus.done !== 1'b0 || bus.busy !== 1'b0) errs++;
      end
      chk("hold_errs", 64'(errs), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/div_reconstruct_mul.md
Name: div_reconstruct_mul

Overview:
Sequential shift-add multiply-accumulate unit that inverts the divider's output. It computes result = Q*B + R from a quotient, divisor and remainder, rebuilding the original dividend. It sits beside the divider as its inverse check path and as a general 32-bit sequential multiplier. It has a start/done handshake and fixed latency.

Parameters:
WIDTH, 32, operand and result width in bits; counter is clog2(WIDTH)+1 bits.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE or DONE
Q  input  WIDTH  quotient / multiplier operand; sampled on accepted start
B  input  WIDTH  divisor / multiplicand operand; sampled on accepted start
R  input  WIDTH  remainder / addend; sampled on accepted start
busy  output  1  high while an operation is in progress (RUN)
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  low WIDTH bits of Q*B+R; held until next accepted start
overflow  output  1  high when Q*B+R >= 2^WIDTH; held with result

Behaviour:
- Reset (rst=1 at a clock edge, overrides everything, including mid-RUN): state=IDLE, busy=0, done=0, result=0, overflow=0. All internal registers are 0. An in-flight operation is discarded, with no done pulse.
- Internal registers:
  - acc: 2*WIDTH bits.
  - mcand: 2*WIDTH bits.
  - mplier: WIDTH bits.
  - cnt: counter.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - acc={0,R}, mcand={0,B}, mplier=Q, cnt=0.
  - Next state RUN, busy=1.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - If mplier[0]=1, then acc = acc + mcand (2*WIDTH-bit add, no carry out possible).
  - mcand shifts left by 1; mplier shifts right by 1 (logical); cnt increments.
- RUN exit: the edge where cnt reaches WIDTH-1 performs the last iteration. On that edge the FSM goes to DONE and loads:
  - result = next acc[WIDTH-1:0]
  - overflow = OR of next acc[2*WIDTH-1:WIDTH]
  - busy=0, done=1
- start is ignored during RUN; there is no queueing.
- DONE: done=1 for exactly one cycle.
  - If start=1, operands are latched and the FSM goes to RUN (back-to-back operation).
  - Otherwise the FSM goes to IDLE.
  - Leaving DONE clears done.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+WIDTH. The latency is fixed and independent of operand values, with no early termination.
- Range: worst case (2^W-1)^2 + (2^W-1) = 2^2W - 2^W fits in 2*WIDTH bits, so acc never wraps.
- result and overflow are registered outputs. They change only on the RUN→DONE edge or on reset, and are stable through IDLE.
- Operand inputs may change freely after the accepted start edge without affecting the operation.
- The arithmetic is unsigned only.

Test Plan:
- Basic: rst 2 cycles; then start with Q=7, B=5, R=3 -> done high exactly 32 cycles after the start edge, result=38, overflow=0, busy high for 32 cycles.
- Round trip with divider: divide A=100 by B=7 to get Q=14, R=2, then feed these in -> result=100, overflow=0. Repeat for 20 random A, B (B≠0) -> result==A every time.
- Extremes: Q=0xFFFFFFFF, B=0xFFFFFFFF, R=0xFFFFFFFF -> result=0x00000000, overflow=1. Q=0, B=0xDEADBEEF, R=0x1234 -> result=0x1234, overflow=0, latency still 32.
- Handshake: after the start with Q=3, B=4, R=0, change operands to Q=9, B=9 and pulse start at cycles 5 and 20 during RUN -> ignored, result=12. Then assert start in the DONE cycle with Q=2, B=2, R=1 -> accepted, next done gives result=5.
- Reset mid-operation: start with Q=100, B=100, R=0, assert rst at cycle 10 -> no done pulse, result=0, busy=0, IDLE. A new start with Q=6, B=7, R=0 then gives 42.
- Hold: after done, with result=38, wait 50 idle cycles with start=0 and random operands -> result=38, overflow=0, done=0, busy=0 throughout.
